// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter
//   Round-robin scheduler placing byte read/write requests from two
//   requesters onto a serial EEPROM engine. It drives the engine strobes,
//   waits for eng_ack, returns completion and read data to the winner, and
//   holds off the next grant for GAP_CYCLES after every completed write.
//
// Parameters
//   GAP_CYCLES : idle cycles forced after each completed write (0 = none)
//   TMO_CYCLES : STROBE cycles allowed without eng_ack before abort
//                (only with EEPROM_ARB_TIMEOUT_EN defined)
//
// Build option
//   EEPROM_ARB_TIMEOUT_EN : enables the STROBE timeout and err0/err1.
//                           Undefined: err0/err1 tied 0, no timeout.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req/we/addr/wdata 0,1      : requester inputs, held until done
//   done/rdata/err 0,1         : completion pulse, read byte, abort flag
//   busy                       : arbiter not idle
//   eng_wr/eng_rd/eng_addr/eng_wdata/eng_data_oe : engine strobes and bus
//   eng_rdata, eng_ack         : engine read data and completion
module eeprom_arbiter #(
  parameter logic [15:0] GAP_CYCLES = 16'd5000,
  parameter logic [19:0] TMO_CYCLES = 20'd200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [10:0] addr0,
  input  logic [10:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic        eng_wr,
  output logic        eng_rd,
  output logic [10:0] eng_addr,
  output logic [7:0]  eng_wdata,
  output logic        eng_data_oe,
  input  logic [7:0]  eng_rdata,
  input  logic        eng_ack
);

  typedef enum logic [1:0] {IDLE, GRANT, STROBE, GAP} state_t;

  state_t      state_reg, state_next;
  logic        id_reg;        // 0/1: requester being served
  logic        we_reg;
  logic [10:0] addr_reg;
  logic [7:0]  wdata_reg;
  logic        last_gnt_reg;  // requester granted most recently
  logic [15:0] gap_cnt_reg;
  logic        done0_reg, done1_reg;
  logic [7:0]  rdata0_reg, rdata1_reg;
  logic        finish;        // engine acked the transaction in flight
  logic        abort;         // transaction in flight timed out
  logic        tmo_hit;
  logic        winner;

  // With both requesting, the one not served last wins.
  assign winner = req1 & (~req0 | ~last_gnt_reg);

`ifdef EEPROM_ARB_TIMEOUT_EN
  logic [19:0] tmo_cnt_reg;
  logic        err0_reg, err1_reg;

  // Cleared in GRANT so it counts STROBE cycles only.
  assign tmo_hit = (tmo_cnt_reg == TMO_CYCLES - 20'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
      err0_reg    <= 1'b0;
      err1_reg    <= 1'b0;
    end else begin
      if (state_reg == GRANT)
        tmo_cnt_reg <= '0;
      else if (state_reg == STROBE)
        tmo_cnt_reg <= tmo_cnt_reg + 20'd1;
      err0_reg <= abort & ~id_reg;
      err1_reg <= abort &  id_reg;
    end
  end

  assign err0 = err0_reg;
  assign err1 = err1_reg;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
  assign tmo_hit    = 1'b0;
  assign err0       = 1'b0;
  assign err1       = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    finish      = 1'b0;
    abort       = 1'b0;
    eng_wr      = 1'b0;
    eng_rd      = 1'b0;
    eng_data_oe = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 | req1)
          state_next = GRANT;
      end
      GRANT: begin
        // A request withdrawn before GRANT leaves nothing to serve.
        state_next = (req0 | req1) ? STROBE : IDLE;
      end
      STROBE: begin
        eng_wr      =  we_reg;
        eng_rd      = ~we_reg;
        eng_data_oe =  we_reg;
        if (eng_ack) begin
          finish     = 1'b1;
          state_next = (we_reg && GAP_CYCLES != 16'd0) ? GAP : IDLE;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_reg == 16'd0)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      id_reg       <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      last_gnt_reg <= 1'b1;
      gap_cnt_reg  <= '0;
      done0_reg    <= 1'b0;
      done1_reg    <= 1'b0;
      rdata0_reg   <= '0;
      rdata1_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == GRANT && (req0 | req1)) begin
        id_reg       <= winner;
        we_reg       <= winner ? we1    : we0;
        addr_reg     <= winner ? addr1  : addr0;
        wdata_reg    <= winner ? wdata1 : wdata0;
        last_gnt_reg <= winner;
      end
      if (finish && we_reg)
        gap_cnt_reg <= GAP_CYCLES - 16'd1;
      else if (state_reg == GAP && gap_cnt_reg != 16'd0)
        gap_cnt_reg <= gap_cnt_reg - 16'd1;
      done0_reg <= (finish | abort) & ~id_reg;
      done1_reg <= (finish | abort) &  id_reg;
      if (finish && !we_reg) begin
        if (id_reg) rdata1_reg <= eng_rdata;
        else        rdata0_reg <= eng_rdata;
      end
    end
  end

  assign done0     = done0_reg;
  assign done1     = done1_reg;
  assign rdata0    = rdata0_reg;
  assign rdata1    = rdata1_reg;
  assign busy      = (state_reg != IDLE);
  assign eng_addr  = addr_reg;
  assign eng_wdata = wdata_reg;

endmodule

// File: tb/tb_eeprom_arbiter.sv
module tb_eeprom_arbiter;

  localparam int GAP = 10;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [10:0] addr0 = 0, addr1 = 0;
  logic [7:0]  wdata0 = 0, wdata1 = 0;
  logic        done0, done1, err0, err1, busy;
  logic [7:0]  rdata0, rdata1;
  logic        eng_wr, eng_rd, eng_data_oe;
  logic [10:0] eng_addr;
  logic [7:0]  eng_wdata;
  logic [7:0]  eng_rdata = 8'h00;
  logic        eng_ack_m = 1'b0;
  logic        spur_ack = 1'b0;
  logic        eng_ack;

  assign eng_ack = eng_ack_m | spur_ack;

  eeprom_arbiter #(.GAP_CYCLES(16'd10), .TMO_CYCLES(20'd50)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .busy(busy),
    .eng_wr(eng_wr), .eng_rd(eng_rd), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_data_oe(eng_data_oe),
    .eng_rdata(eng_rdata), .eng_ack(eng_ack)
  );

  always #5 clk = ~clk;

  // Engine model: acks ack_delay+1 cycles after the strobe rises.
  int         ack_delay = 2;
  bit         ack_en = 1'b1;
  int         eng_cnt = 0;
  bit         init_done = 1'b0;
  logic [7:0] emem [2048];

  always @(posedge clk) begin
    eng_ack_m <= 1'b0;
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) emem[i] <= 8'(i) ^ 8'h5A;
      emem[2047] <= 8'h3C;
      init_done  <= 1'b1;
    end else if ((eng_wr || eng_rd) && !eng_ack_m && ack_en) begin
      if (eng_cnt == ack_delay) begin
        eng_ack_m <= 1'b1;
        eng_cnt   <= 0;
        if (eng_rd) eng_rdata <= emem[eng_addr];
        if (eng_wr) emem[eng_addr] <= eng_wdata;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end else if (!(eng_wr || eng_rd)) begin
      eng_cnt <= 0;
    end
  end

  // Reference model state
  logic [7:0] ref_mem [2048];
  logic [7:0] ref_rdata [2];
  bit         ref_last;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise the selected requests and follow them to completion, checking
  // arbitration order, engine strobes, read data, done width and timing.
  task automatic serve(input bit r0, input bit r1);
    int         order [2];
    int         n, served, next_strobe, gap_end, last_done_port, p;
    bit         prev_strobe, strobe, both, finished, pw;
    logic [10:0] o_addr, pa;
    logic [7:0]  o_wdata, pd;
    logic        o_wr, o_rd, o_oe;
    n = int'(r0) + int'(r1);
    if (r0 && r1) begin
      order[0] = ref_last ? 0 : 1;
      order[1] = 1 - order[0];
    end else begin
      order[0] = r1 ? 1 : 0;
      order[1] = 0;
    end
    served = 0; next_strobe = 2; gap_end = -1; last_done_port = -1;
    prev_strobe = 0; both = 0; finished = 0;
    o_addr = '0; o_wdata = '0; o_wr = 0; o_rd = 0; o_oe = 0;
    @(negedge clk);
    req0 = r0; req1 = r1;
    for (int iter = 1; iter <= 3000; iter++) begin
      @(negedge clk);
      strobe = eng_wr | eng_rd;
      if (eng_wr & eng_rd) both = 1;
      if (strobe) begin
        o_addr = eng_addr; o_wdata = eng_wdata;
        o_wr = eng_wr; o_rd = eng_rd; o_oe = eng_data_oe;
      end
      if (strobe && !prev_strobe) chk("strobe_start_cycle", iter, next_strobe);
      prev_strobe = strobe;
      if (last_done_port >= 0) begin
        chk("done_one_cycle", last_done_port == 1 ? done1 : done0, 0);
        last_done_port = -1;
      end
      if (iter == gap_end - 1) chk("gap_busy_high", busy, 1);
      if (iter == gap_end && served > 0) chk("busy_after_gap", busy, 0);
      if (done0 | done1) begin
        p  = done1 ? 1 : 0;
        pw = p ? we1 : we0;
        pa = p ? addr1 : addr0;
        pd = p ? wdata1 : wdata0;
        chk("done_exclusive", done0 & done1, 0);
        chk("grant_order", p, order[served]);
        chk("eng_addr", o_addr, pa);
        chk("eng_wr", o_wr, pw);
        chk("eng_rd", o_rd, !pw);
        chk("eng_data_oe", o_oe, pw);
        if (pw) chk("eng_wdata", o_wdata, pd);
        chk("wr_rd_exclusive", both, 0);
        if (pw) ref_mem[pa] = pd;
        else    ref_rdata[p] = ref_mem[pa];
        chk("rdata", p ? rdata1 : rdata0, ref_rdata[p]);
        chk("err", p ? err1 : err0, 0);
        ref_last = p[0];
        if (p == 1) req1 = 0; else req0 = 0;
        last_done_port = p;
        served++;
        both = 0;
        gap_end = pw ? iter + GAP : iter;
        next_strobe = iter + (pw ? GAP : 0) + 2;
      end
      if (served == n && iter > gap_end && last_done_port < 0) begin
        finished = 1;
        break;
      end
    end
    chk("serve_completed", finished, 1);
    req0 = 0; req1 = 0;
  endtask

  task automatic set_port(input int p, input bit w, input logic [10:0] a, input logic [7:0] d);
    if (p == 1) begin we1 = w; addr1 = a; wdata1 = d; end
    else        begin we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic apply_reset_mid(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, "_eng_wr"}, eng_wr, 0);
    chk({tag, "_eng_rd"}, eng_rd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_eng_addr"}, eng_addr, 0);
    req0 = 0; req1 = 0;
    ref_last = 1;
    ref_rdata[0] = 8'h00; ref_rdata[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit seen_done, got;
  int cnt;

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    ref_mem[2047] = 8'h3C;
    ref_rdata[0] = 8'h00; ref_rdata[1] = 8'h00;
    ref_last = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done0", done0, 0);   chk("rst_done1", done1, 0);
    chk("rst_err0", err0, 0);     chk("rst_err1", err1, 0);
    chk("rst_busy", busy, 0);     chk("rst_eng_wr", eng_wr, 0);
    chk("rst_eng_rd", eng_rd, 0); chk("rst_data_oe", eng_data_oe, 0);
    chk("rst_eng_addr", eng_addr, 0); chk("rst_eng_wdata", eng_wdata, 0);
    chk("rst_rdata0", rdata0, 0); chk("rst_rdata1", rdata1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Tie from reset: port 0 first, then port 1; then repeated tie
    set_port(0, 1, 11'h010, 8'h11);
    set_port(1, 0, 11'h010, 8'h00);
    serve(1, 1);
    set_port(0, 0, 11'h010, 8'h00);
    set_port(1, 1, 11'h011, 8'h22);
    serve(1, 1);

    // Single write with a slow engine
    ack_delay = 39;
    set_port(0, 1, 11'h123, 8'hA5);
    serve(1, 0);

    // Single read of the top address
    ack_delay = 3;
    set_port(1, 0, 11'h7FF, 8'h00);
    serve(0, 1);

    // Back-to-back writes on a tie
    set_port(0, 1, 11'h005, 8'hC3);
    set_port(1, 1, 11'h006, 8'h3C);
    serve(1, 1);

    // Spurious ack while idle is ignored
    @(negedge clk); spur_ack = 1;
    @(negedge clk); spur_ack = 0;
    chk("spur_ack_busy", busy, 0);
    chk("spur_ack_done", done0 | done1, 0);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      int sel;
      sel = $urandom_range(2, 0);
      ack_delay = $urandom_range(5, 0);
      set_port(0, 1'($urandom), 11'($urandom_range(15, 0)), 8'($urandom));
      set_port(1, 1'($urandom), 11'($urandom_range(15, 0)), 8'($urandom));
      serve(sel != 1, sel != 0);
    end

    // Engine never acks
    ack_en = 0;
    set_port(0, 1, 11'h020, 8'h77);
`ifdef EEPROM_ARB_TIMEOUT_EN
    @(negedge clk); req0 = 1;
    cnt = 0; got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (eng_wr | eng_rd) cnt++;
      if (done0) begin
        got = 1;
        chk("tmo_err0", err0, 1);
        chk("tmo_strobe_low", eng_wr, 0);
        chk("tmo_rdata0", rdata0, ref_rdata[0]);
        chk("tmo_no_gap", busy, 0);
        break;
      end
    end
    chk("tmo_done_seen", got, 1);
    chk("tmo_strobe_cycles", cnt, TMO);
    req0 = 0;
    ref_last = 0;
    @(negedge clk);
    chk("tmo_err_one_cycle", err0, 0);
`else
    @(negedge clk); req0 = 1;
    seen_done = 0;
    repeat (300) begin
      @(negedge clk);
      if (done0 | done1) seen_done = 1;
    end
    chk("no_tmo_strobe_held", eng_wr, 1);
    chk("no_tmo_no_done", seen_done, 0);
    apply_reset_mid("no_tmo_reset");
`endif
    ack_en = 1;

    // Reset asserted during STROBE of a read
    ack_delay = 40;
    set_port(1, 0, 11'h003, 8'h00);
    @(negedge clk); req1 = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eng_rd) begin got = 1; break; end
    end
    chk("rst_mid_strobe_seen", got, 1);
    repeat (5) @(negedge clk);
    apply_reset_mid("rst_mid");
    seen_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (done0 | done1) seen_done = 1;
    end
    chk("rst_mid_no_done", seen_done, 0);
    chk("rst_mid_rdata1", rdata1, 0);

    // Normal service after reset release
    ack_delay = 2;
    serve(0, 1);
    set_port(0, 0, 11'h003, 8'h00);
    serve(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Two-port scheduler in front of the serial EEPROM read/write engine. Accepts byte read/write requests from two independent requesters, arbitrates round-robin, drives the engine's WR/RD/ADDR/DATA strobes, waits for the engine's ACK, and returns completion and read data to the winning requester. It enforces a programmable post-write recovery gap so the EEPROM's internal write cycle is never violated.

## Interface
- GAP_CYCLES, 16'd5000: idle cycles forced after every completed write before the next grant.
- TMO_CYCLES, 20'd200000: cycles allowed between strobe assertion and ACK before abort (used only with timeout compiled in).
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- req0, req1  input  1  request level; held until matching done.
- we0, we1  input  1  1 = write, 0 = read; stable while req high.
- addr0, addr1  input  11  byte address; stable while req high.
- wdata0, wdata1  input  8  write byte; stable while req high.
- done0, done1  output  1  one-cycle completion pulse.
- rdata0, rdata1  output  8  read byte, valid in the done cycle, held until the next completion on that port.
- err0, err1  output  1  one-cycle, coincident with done; 1 = transaction aborted.
- busy  output  1  high whenever state != IDLE.
- eng_wr, eng_rd  output  1  engine write/read strobes.
- eng_addr  output  11  engine address.
- eng_wdata  output  8  engine write data.
- eng_data_oe  output  1  1 = top level drives eng_wdata onto engine DATA bus.
- eng_rdata  input  8  engine DATA bus as seen by the arbiter.
- eng_ack  input  1  engine one-cycle ACK at end of a transaction.

## Operation
- States: IDLE, GRANT, STROBE, GAP.
- IDLE: if any req high -> GRANT. Winner: the only requester asserting; if both, the one not served last (last_gnt flag). After reset last_gnt=1, so requester 0 wins the first tie.
- GRANT (1 cycle): latch winner id, we, addr, wdata into internal registers; update last_gnt.
- STROBE: eng_wr=we_l, eng_rd=~we_l held high; eng_addr/eng_wdata from latches; eng_data_oe=we_l. On eng_ack: drop strobes, capture eng_rdata into rdata<id> if read, pulse done<id>. Write -> GAP; read -> IDLE.
- GAP: 16-bit down-counter loaded with GAP_CYCLES-1; -> IDLE at 0. GAP_CYCLES=0 bypasses GAP (write returns straight to IDLE).
- Requests arriving during any non-IDLE state wait; requester inputs are never sampled outside GRANT.
- A requester dropping req before done is a protocol violation; the transaction in flight still completes and done still pulses.
- eng_wr and eng_rd are never high together.

## Timing
- Reset values: done*, err*, busy, eng_wr, eng_rd, eng_data_oe = 0; eng_addr, eng_wdata, rdata* = 0; state IDLE; last_gnt=1.
- req high in cycle N (IDLE) -> GRANT at N+1 -> strobes high at N+2.
- eng_ack in cycle M -> strobes low and done/rdata at M+1; next grant earliest M+2 after a read, M+2+GAP_CYCLES after a write.
- eng_ack outside STROBE is ignored.
- Reset asserted mid-transaction: all outputs to reset values immediately; no done is issued for the aborted transaction.

## Configuration
- EEPROM_ARB_TIMEOUT_EN defined: 20-bit counter runs in STROBE; reaching TMO_CYCLES without eng_ack drops strobes, pulses done<id> and err<id> together, rdata unchanged, -> IDLE (no GAP).
- Not defined: no counter, err0/err1 tied 0, STROBE waits for eng_ack indefinitely.

## Test plan
- Single write: req0, we0=1, addr0=11'h123, wdata0=8'hA5; engine model acks 40 cycles after strobe -> eng_wr high with eng_addr=11'h123, eng_wdata=8'hA5, eng_data_oe=1; done0 one cycle; busy low exactly GAP_CYCLES cycles later.
- Single read: req1, we1=0, addr1=11'h7FF; model drives 8'h3C with ack -> eng_rd high, done1 with rdata1=8'h3C, eng_data_oe=0 throughout, no GAP.
- Tie: req0 and req1 raised same cycle from reset -> port 0 served first, then port 1; repeat tie -> port 1 first this time.
- Back-to-back writes GAP_CYCLES=10: second grant no earlier than 12 cycles after first eng_ack.
- Timeout (macro defined, TMO_CYCLES=50): model never acks -> strobe low and done0+err0 after 50 STROBE cycles; without macro, strobe held indefinitely.
- Reset pulse low during STROBE -> eng_wr/eng_rd 0 immediately, no done, next request granted normally after reset release.
